// File: rtl/inst_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// inst_dispatch_buffer
//
// Reader end of the instruction queue. Pops {valid, pc, inst} packets, holds
// up to two of them in an in-order skid buffer (E0 = head, E1 = next) and
// presents the head, field-split, to dispatch. Back-pressure from the ROB or
// the reservation station stalls the head while the second slot keeps the
// queue draining for one more packet. A branch mispredict empties the buffer
// in the same cycle the queue flushes. Sequence tags are never rewound by a
// flush, only by reset.
//
// Optional feature: define DISPATCH_PERF_EN to build two saturating stall
// counters (ROB stall, reservation-station stall). Without the macro the perf
// ports are tied to zero and no counter flops exist.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   branch_mispredict   flush request (same cycle as the queue flush)
//   q_empty, q_packet   queue head status and packet {valid, pc, inst}
//   q_pop               head of queue is removed at this clock edge
//   rob_full            ROB cannot accept
//   reservation_full    reservation station cannot accept
//   dispatch_*          head entry and its decode slices, plus its seq tag
//   perf_rob_stall      cycles the head was blocked by the ROB
//   perf_rs_stall       cycles the head was blocked by the reservation station
// -----------------------------------------------------------------------------
module inst_dispatch_buffer #(
  parameter int SEQ_W  = 8,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              branch_mispredict,
  input  logic              q_empty,
  input  logic [64:0]       q_packet,
  output logic              q_pop,
  input  logic              rob_full,
  input  logic              reservation_full,
  output logic              dispatch_valid,
  output logic [31:0]       dispatch_pc,
  output logic [31:0]       dispatch_inst,
  output logic [6:0]        dispatch_opcode,
  output logic [4:0]        dispatch_rd,
  output logic [2:0]        dispatch_funct3,
  output logic [4:0]        dispatch_rs1,
  output logic [4:0]        dispatch_rs2,
  output logic [SEQ_W-1:0]  dispatch_seq,
  output logic [PERF_W-1:0] perf_rob_stall,
  output logic [PERF_W-1:0] perf_rs_stall
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       e0_pc_q, e0_pc_d, e0_inst_q, e0_inst_d;
  logic [31:0]       e1_pc_q, e1_pc_d, e1_inst_q, e1_inst_d;
  logic [SEQ_W-1:0]  e0_seq_q, e0_seq_d, e1_seq_q, e1_seq_d;
  logic [SEQ_W-1:0]  seq_q, seq_d;

  logic              valid_s;
  logic              fire_s;
  logic              pop_s;
  logic              accept_s;
  logic [31:0]       pkt_pc_s;
  logic [31:0]       pkt_inst_s;

  // Gating with rst keeps both handshake outputs low for the whole reset
  // pulse, even while the queue head is non-empty.
  assign valid_s    = !rst && (state_q != S_EMPTY) && !branch_mispredict;
  assign fire_s     = valid_s && !rob_full && !reservation_full;
  // A full buffer can still take a packet when the head leaves this cycle.
  assign pop_s      = !rst && !q_empty && !branch_mispredict &&
                      ((state_q != S_TWO) || fire_s);
  // Bubbles (valid bit clear) are popped but otherwise ignored.
  assign accept_s   = pop_s && q_packet[64];
  assign pkt_pc_s   = q_packet[63:32];
  assign pkt_inst_s = q_packet[31:0];

  assign q_pop           = pop_s;
  assign dispatch_valid  = valid_s;
  assign dispatch_pc     = e0_pc_q;
  assign dispatch_inst   = e0_inst_q;
  assign dispatch_opcode = e0_inst_q[6:0];
  assign dispatch_rd     = e0_inst_q[11:7];
  assign dispatch_funct3 = e0_inst_q[14:12];
  assign dispatch_rs1    = e0_inst_q[19:15];
  assign dispatch_rs2    = e0_inst_q[24:20];
  assign dispatch_seq    = e0_seq_q;

  // Next-state logic for the occupancy FSM, both entries and the seq counter.
  always_comb begin
    state_d   = state_q;
    e0_pc_d   = e0_pc_q;
    e0_inst_d = e0_inst_q;
    e0_seq_d  = e0_seq_q;
    e1_pc_d   = e1_pc_q;
    e1_inst_d = e1_inst_q;
    e1_seq_d  = e1_seq_q;

    // Accept never happens during a flush, so tags survive it untouched.
    if (accept_s) begin
      seq_d = seq_q + {{(SEQ_W-1){1'b0}}, 1'b1};
    end else begin
      seq_d = seq_q;
    end

    if (branch_mispredict) begin
      state_d = S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept_s) begin
            state_d   = S_ONE;
            e0_pc_d   = pkt_pc_s;
            e0_inst_d = pkt_inst_s;
            e0_seq_d  = seq_q;
          end else begin
            state_d = S_EMPTY;
          end
        end
        S_ONE: begin
          if (accept_s && !fire_s) begin
            state_d   = S_TWO;
            e1_pc_d   = pkt_pc_s;
            e1_inst_d = pkt_inst_s;
            e1_seq_d  = seq_q;
          end else if (fire_s && !accept_s) begin
            state_d = S_EMPTY;
          end else if (fire_s && accept_s) begin
            state_d   = S_ONE;
            e0_pc_d   = pkt_pc_s;
            e0_inst_d = pkt_inst_s;
            e0_seq_d  = seq_q;
          end else begin
            state_d = S_ONE;
          end
        end
        S_TWO: begin
          if (fire_s) begin
            e0_pc_d   = e1_pc_q;
            e0_inst_d = e1_inst_q;
            e0_seq_d  = e1_seq_q;
            if (accept_s) begin
              state_d   = S_TWO;
              e1_pc_d   = pkt_pc_s;
              e1_inst_d = pkt_inst_s;
              e1_seq_d  = seq_q;
            end else begin
              state_d = S_ONE;
            end
          end else begin
            state_d = S_TWO;
          end
        end
        default: begin
          state_d = S_EMPTY;
        end
      endcase
    end
  end

  // State, entry and seq-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_EMPTY;
      e0_pc_q   <= 32'd0;
      e0_inst_q <= 32'd0;
      e0_seq_q  <= {SEQ_W{1'b0}};
      e1_pc_q   <= 32'd0;
      e1_inst_q <= 32'd0;
      e1_seq_q  <= {SEQ_W{1'b0}};
      seq_q     <= {SEQ_W{1'b0}};
    end else begin
      state_q   <= state_d;
      e0_pc_q   <= e0_pc_d;
      e0_inst_q <= e0_inst_d;
      e0_seq_q  <= e0_seq_d;
      e1_pc_q   <= e1_pc_d;
      e1_inst_q <= e1_inst_d;
      e1_seq_q  <= e1_seq_d;
      seq_q     <= seq_d;
    end
  end

`ifdef DISPATCH_PERF_EN
  logic [PERF_W-1:0] perf_rob_q, perf_rob_d;
  logic [PERF_W-1:0] perf_rs_q, perf_rs_d;

  // Saturating stall counters; both may step in the same cycle.
  always_comb begin
    if (valid_s && rob_full && (perf_rob_q != {PERF_W{1'b1}})) begin
      perf_rob_d = perf_rob_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      perf_rob_d = perf_rob_q;
    end
    if (valid_s && reservation_full && (perf_rs_q != {PERF_W{1'b1}})) begin
      perf_rs_d = perf_rs_q + {{(PERF_W-1){1'b0}}, 1'b1};
    end else begin
      perf_rs_d = perf_rs_q;
    end
  end

  // Stall counter registers; only reset clears them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_rob_q <= {PERF_W{1'b0}};
      perf_rs_q  <= {PERF_W{1'b0}};
    end else begin
      perf_rob_q <= perf_rob_d;
      perf_rs_q  <= perf_rs_d;
    end
  end

  assign perf_rob_stall = perf_rob_q;
  assign perf_rs_stall  = perf_rs_q;
`else
  assign perf_rob_stall = {PERF_W{1'b0}};
  assign perf_rs_stall  = {PERF_W{1'b0}};
`endif

endmodule

// File: tb/tb_inst_dispatch_buffer.sv
// -----------------------------------------------------------------------------
// Bench for inst_dispatch_buffer. A queue model feeds q_packet/q_empty; every
// packet the model expects to be accepted is pushed onto a scoreboard with the
// seq tag the model assigns, and the head of the scoreboard is compared with
// the dispatch outputs each cycle. Expected q_pop / dispatch_valid come from
// the model's occupancy (scoreboard depth).
// -----------------------------------------------------------------------------
module tb_inst_dispatch_buffer;

  localparam int SEQ_W  = 8;
  localparam int PERF_W = 4;

  typedef struct packed {
    logic [31:0]      pc;
    logic [31:0]      inst;
    logic [SEQ_W-1:0] seq;
  } ent_t;

  logic              clk;
  logic              rst;
  logic              branch_mispredict;
  logic              q_empty;
  logic [64:0]       q_packet;
  logic              q_pop;
  logic              rob_full;
  logic              reservation_full;
  logic              dispatch_valid;
  logic [31:0]       dispatch_pc;
  logic [31:0]       dispatch_inst;
  logic [6:0]        dispatch_opcode;
  logic [4:0]        dispatch_rd;
  logic [2:0]        dispatch_funct3;
  logic [4:0]        dispatch_rs1;
  logic [4:0]        dispatch_rs2;
  logic [SEQ_W-1:0]  dispatch_seq;
  logic [PERF_W-1:0] perf_rob_stall;
  logic [PERF_W-1:0] perf_rs_stall;

  int n_vec = 0;
  int n_err = 0;

  logic [64:0]       fq[$];
  ent_t              sb[$];
  logic [SEQ_W-1:0]  m_seq;
  logic [PERF_W-1:0] m_rob;
  logic [PERF_W-1:0] m_rs;

  inst_dispatch_buffer #(.SEQ_W(SEQ_W), .PERF_W(PERF_W)) dut (
    .clk               (clk),
    .rst               (rst),
    .branch_mispredict (branch_mispredict),
    .q_empty           (q_empty),
    .q_packet          (q_packet),
    .q_pop             (q_pop),
    .rob_full          (rob_full),
    .reservation_full  (reservation_full),
    .dispatch_valid    (dispatch_valid),
    .dispatch_pc       (dispatch_pc),
    .dispatch_inst     (dispatch_inst),
    .dispatch_opcode   (dispatch_opcode),
    .dispatch_rd       (dispatch_rd),
    .dispatch_funct3   (dispatch_funct3),
    .dispatch_rs1      (dispatch_rs1),
    .dispatch_rs2      (dispatch_rs2),
    .dispatch_seq      (dispatch_seq),
    .perf_rob_stall    (perf_rob_stall),
    .perf_rs_stall     (perf_rs_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive_q();
    q_empty  = (fq.size() == 0);
    q_packet = (fq.size() != 0) ? fq[0] : 65'd0;
  endtask

  task automatic push_pkt(input logic v, input logic [31:0] pc);
    logic [64:0] p;
    p = {v, pc, 32'($urandom)};
    fq.push_back(p);
    drive_q();
  endtask

  // One clock: check outputs at the falling edge, advance the model at the
  // rising edge, then present the new queue head.
  task automatic cycle();
    logic exp_valid, exp_fire, exp_pop;
    logic [64:0] p;
    ent_t e;
    @(negedge clk);
    exp_valid = !rst && (sb.size() > 0) && !branch_mispredict;
    exp_fire  = exp_valid && !rob_full && !reservation_full;
    exp_pop   = !rst && (fq.size() > 0) && !branch_mispredict &&
                ((sb.size() < 2) || exp_fire);
    check_eq("dispatch_valid", 64'(dispatch_valid), 64'(exp_valid));
    check_eq("q_pop", 64'(q_pop), 64'(exp_pop));
    check_eq("perf_rob", 64'(perf_rob_stall), 64'(m_rob));
    check_eq("perf_rs", 64'(perf_rs_stall), 64'(m_rs));
    if (exp_valid) begin
      e = sb[0];
      check_eq("pc", 64'(dispatch_pc), 64'(e.pc));
      check_eq("inst", 64'(dispatch_inst), 64'(e.inst));
      check_eq("seq", 64'(dispatch_seq), 64'(e.seq));
      check_eq("opcode", 64'(dispatch_opcode), 64'(e.inst[6:0]));
      check_eq("rd", 64'(dispatch_rd), 64'(e.inst[11:7]));
      check_eq("funct3", 64'(dispatch_funct3), 64'(e.inst[14:12]));
      check_eq("rs1", 64'(dispatch_rs1), 64'(e.inst[19:15]));
      check_eq("rs2", 64'(dispatch_rs2), 64'(e.inst[24:20]));
    end
    @(posedge clk);
    if (!rst) begin
`ifdef DISPATCH_PERF_EN
      if (exp_valid && rob_full && m_rob != {PERF_W{1'b1}}) m_rob = m_rob + 4'd1;
      if (exp_valid && reservation_full && m_rs != {PERF_W{1'b1}}) m_rs = m_rs + 4'd1;
`endif
      if (branch_mispredict) begin
        sb.delete();
        fq.delete();
      end else begin
        if (exp_fire) void'(sb.pop_front());
        if (exp_pop) begin
          p = fq.pop_front();
          if (p[64]) begin
            e.pc   = p[63:32];
            e.inst = p[31:0];
            e.seq  = m_seq;
            sb.push_back(e);
            m_seq  = m_seq + 8'd1;
          end
        end
      end
    end
    #1;
    drive_q();
  endtask

  task automatic run_idle(input int budget);
    logic idle;
    idle = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sb.size() == 0 && fq.size() == 0) begin
        idle = 1'b1;
        break;
      end
      cycle();
    end
    if (sb.size() == 0 && fq.size() == 0) idle = 1'b1;
    check_eq("drain_budget", 64'(idle), 64'd1);
  endtask

  initial begin
    rst               = 1'b1;
    branch_mispredict = 1'b0;
    rob_full          = 1'b0;
    reservation_full  = 1'b0;
    m_seq             = 8'd0;
    m_rob             = 4'd0;
    m_rs              = 4'd0;
    drive_q();

    // Reset with a non-empty queue: nothing may pop or dispatch.
    push_pkt(1'b1, 32'h1000);
    push_pkt(1'b1, 32'h1004);
    push_pkt(1'b1, 32'h1008);
    cycle();
    cycle();
    rst = 1'b0;

    // Streaming, no back-pressure.
    run_idle(10);

    // ROB back-pressure: buffer fills to two, then drains in order.
    rob_full = 1'b1;
    push_pkt(1'b1, 32'h1000);
    push_pkt(1'b1, 32'h1004);
    push_pkt(1'b1, 32'h1008);
    for (int i = 0; i < 4; i++) cycle();
    check_eq("bp_head_pc", 64'(dispatch_pc), 64'h1000);
    rob_full = 1'b0;
    reservation_full = 1'b1;
    cycle();
    reservation_full = 1'b0;
    run_idle(10);

    // Bubble then a real instruction: the bubble takes no seq.
    push_pkt(1'b0, 32'hdead);
    push_pkt(1'b1, 32'h2000);
    run_idle(10);

    // Flush while full.
    rob_full = 1'b1;
    push_pkt(1'b1, 32'h3000);
    push_pkt(1'b1, 32'h3004);
    push_pkt(1'b1, 32'h3008);
    for (int i = 0; i < 3; i++) cycle();
    branch_mispredict = 1'b1;
    cycle();
    branch_mispredict = 1'b0;
    rob_full = 1'b0;
    cycle();
    push_pkt(1'b1, 32'h4000);
    run_idle(10);

    // Randomised traffic, back-pressure and occasional flushes.
    for (int i = 0; i < 120; i++) begin
      if ($urandom_range(0, 2) != 0) push_pkt($urandom_range(0, 4) != 0, 32'h5000 + 32'(i * 4));
      rob_full          = ($urandom_range(0, 3) == 0);
      reservation_full  = ($urandom_range(0, 3) == 0);
      branch_mispredict = ($urandom_range(0, 24) == 0);
      cycle();
    end
    branch_mispredict = 1'b0;
    rob_full          = 1'b0;
    reservation_full  = 1'b0;
    run_idle(20);

    // 257 dispatches: seq wraps 255 -> 0.
    for (int i = 0; i < 257; i++) push_pkt(1'b1, 32'h8000_0000 + 32'(i * 4));
    run_idle(400);

    // Both consumers full long enough to saturate the stall counters.
    rob_full         = 1'b1;
    reservation_full = 1'b1;
    push_pkt(1'b1, 32'h6000);
    for (int i = 0; i < 20; i++) cycle();
`ifdef DISPATCH_PERF_EN
    check_eq("perf_rob_sat", 64'(perf_rob_stall), 64'd15);
    check_eq("perf_rs_sat", 64'(perf_rs_stall), 64'd15);
`else
    check_eq("perf_rob_off", 64'(perf_rob_stall), 64'd0);
    check_eq("perf_rs_off", 64'(perf_rs_stall), 64'd0);
`endif

    // Reach TWO, then reset asynchronously between clock edges.
    push_pkt(1'b1, 32'h6004);
    push_pkt(1'b1, 32'h6008);
    cycle();
    cycle();
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_valid", 64'(dispatch_valid), 64'd0);
    check_eq("async_rst_pop", 64'(q_pop), 64'd0);
    sb.delete();
    m_seq = 8'd0;
    m_rob = 4'd0;
    m_rs  = 4'd0;
    cycle();
    rst              = 1'b0;
    rob_full         = 1'b0;
    reservation_full = 1'b0;
    push_pkt(1'b1, 32'h7000);
    run_idle(10);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_dispatch_buffer.md
Name: inst_dispatch_buffer

Overview:
- Reader end of the instruction queue: pops the 65-bit queue packets {valid, pc[31:0], inst[31:0]} that fetch pushes.
- Holds them in a 2-entry in-order skid buffer and presents the oldest one, field-split, to dispatch (ROB allocation plus reservation-station write).
- Absorbs ROB and reservation-station back-pressure so the queue keeps draining without dropping instructions.
- On branch_mispredict it flushes its own contents, in step with the queue flush.

Parameters:
SEQ_W, 8, width of the dispatch sequence tag; wraps modulo 2^SEQ_W.
PERF_W, 16, width of each saturating stall counter (used only with the optional feature).

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
branch_mispredict  in  1  flush request; same cycle the queue flushes
q_empty  in  1  instruction queue empty
q_packet  in  65  queue head {valid, pc, inst}; meaningful only when !q_empty
q_pop  out  1  pop queue head at this clock edge
rob_full  in  1  ROB cannot accept
reservation_full  in  1  reservation station cannot accept
dispatch_valid  out  1  head entry presented
dispatch_pc  out  32  head pc
dispatch_inst  out  32  head raw instruction
dispatch_opcode  out  7  inst[6:0]
dispatch_rd  out  5  inst[11:7]
dispatch_funct3  out  3  inst[14:12]
dispatch_rs1  out  5  inst[19:15]
dispatch_rs2  out  5  inst[24:20]
dispatch_seq  out  SEQ_W  sequence tag of head entry
perf_rob_stall  out  PERF_W  cycles blocked by ROB (optional feature)
perf_rs_stall  out  PERF_W  cycles blocked by reservation station (optional feature)

Behaviour:
- Storage and state:
  - Two entry registers, E0 (head) and E1. Each holds pc, inst and seq.
  - State machine: EMPTY, ONE (E0 valid), TWO (E0, E1 valid). All state is reset asynchronously: state=EMPTY, seq counter=0, perf counters=0.
- Outputs:
  - dispatch_* outputs are driven combinationally from E0. Decode fields are pure bit slices.
  - dispatch_valid = (state!=EMPTY) && !branch_mispredict. It is 0 during reset.
- Dispatch handshake:
  - fire = dispatch_valid && !rob_full && !reservation_full. The consumer samples dispatch_* in the fire cycle.
  - On fire, E0 retires at the clock edge.
- Queue pop:
  - q_pop = !q_empty && !branch_mispredict && (state!=TWO || fire). It is 0 during reset.
  - Queue latency is zero: q_packet is the current head, and it is removed at the edge where q_pop=1.
- Accept and seq tag:
  - accept = q_pop && q_packet[64].
  - A popped packet with valid bit 0 is discarded. It consumes no seq and causes no state change.
  - An accepted entry gets seq = current counter; the counter increments by 1 and wraps.
- Transitions (neither = no accept and no fire):
  - EMPTY: accept -> ONE (E0=pkt). Otherwise stay.
  - ONE: accept && !fire -> TWO (E1=pkt). fire && !accept -> EMPTY. accept && fire -> ONE (E0=pkt). Neither -> stay.
  - TWO: fire && accept -> TWO (E0=E1, E1=pkt). fire && !accept -> ONE (E0=E1). Neither -> stay. accept without fire cannot occur.
- Flush:
  - branch_mispredict -> state=EMPTY at the next edge, regardless of other inputs.
  - No fire and no pop occur in that cycle.
  - The seq counter is NOT reset by flush; tags stay monotonic across flushes.
- Ordering: entries dispatch strictly in pop order. Throughput is one dispatch per cycle when the queue is non-empty and there is no back-pressure.
- Reset mid-operation clears all entries immediately. Outputs return to reset values asynchronously.

Optional Feature:
- Macro DISPATCH_PERF_EN.
- When defined:
  - perf_rob_stall increments each cycle with dispatch_valid && rob_full.
  - perf_rs_stall increments each cycle with dispatch_valid && reservation_full.
  - Both count in the same cycle if both are full. Both saturate at 2^PERF_W-1.
  - Cleared only by rst; flush does not clear them.
- When undefined: no counter flops; both ports are tied to 0.

Test Plan:
- Streaming: reset, queue holds pcs 0x1000, 0x1004, 0x1008 all valid, no back-pressure -> one fire per cycle in that order with seq 0, 1, 2; q_pop high 3 consecutive cycles.
- Back-pressure: rob_full=1 with queue non-empty -> state reaches TWO after 2 pops, q_pop=0 afterward, dispatch_pc stays 0x1000. Drop rob_full -> dispatch of 0x1000 and 0x1004 then 0x1008 on consecutive cycles, no loss.
- Bubble drop: head packet has valid bit 0, next is pc 0x2000 -> both popped, only 0x2000 dispatched, carrying seq n (not n+1).
- Flush: state TWO plus branch_mispredict pulse -> dispatch_valid=0 and q_pop=0 that cycle, EMPTY next cycle. Next accepted instruction gets seq continuing the prior count.
- Wrap and reset: SEQ_W=8, 257 dispatches -> seq 255 followed by 0. Assert rst while in TWO -> dispatch_valid=0 immediately with no clock edge; seq=0 afterward.
- Perf (DISPATCH_PERF_EN, PERF_W=4): hold rob_full and reservation_full for 20 cycles with an entry present -> both counters read 15 (saturated). Without the macro -> both read 0.
